rock_driver: RTL

ROCK_DRIVER -- requirements
Module: rock_driver

---
 rtl/rock_driver.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rock_driver.sv
// Rocking motor driver: frequency/amplitude setpoints, half-period timing, PWM and fault FSM.
// Optional ROCK_DRIVER_SOFTSTART_EN ramps the effective amplitude one step per half-period.
module rock_driver #(
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned FREQ_INIT = 4,
  parameter int unsigned AMP_INIT  = 15,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       step,
  input  logic       Fplus,
  input  logic       Fmin,
  input  logic       Amin,
  input  logic       ERROR,
  input  logic       clear,
  output logic [3:0] freq,
  output logic [3:0] amp,
  output logic       motor_pwm,
  output logic       motor_dir,
  output logic [1:0] state,
  output logic       fault
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2, FAULT = 2'd3} state_t;

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned EW = $clog2(ERR_LIMIT + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [EW-1:0] ERR_MAX = EW'(ERR_LIMIT);

  state_t          st, st_nx;
  logic [PW-1:0]   pre;
  logic [3:0]      hp_cnt, freq_act, pwm_cnt, amp_eff, freq_nx, amp_nx;
  logic [EW-1:0]   err_cnt, err_nx;
  logic            running, boundary, live_step, trip, leave_idle;

`ifdef ROCK_DRIVER_SOFTSTART_EN
  logic [3:0] ss_lvl;
  // A lowered amp clamps the ramp level combinationally, not a cycle later.
  assign amp_eff = (ss_lvl > amp) ? amp : ss_lvl;
`else
  assign amp_eff = amp;
`endif

  always_comb begin
    running    = (st == RUN) || (st == STOP);
    boundary   = running && (pre == PRE_MAX) && (hp_cnt == (4'd15 - freq_act));
    live_step  = step && (st != FAULT);
    freq_nx    = freq;
    amp_nx     = amp;
    err_nx     = err_cnt;
    trip       = 1'b0;
    if (live_step) begin
      if (Fplus && !Fmin && freq != 4'd15)      freq_nx = freq + 4'd1;
      else if (Fmin && !Fplus && freq > 4'd1)   freq_nx = freq - 4'd1;
      if (Amin && amp != 4'd0)                  amp_nx  = amp - 4'd1;
      if (ERROR) begin
        err_nx = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + 1'b1;
        trip   = (err_nx == ERR_MAX);
      end else begin
        err_nx = '0;
      end
    end
    st_nx = st;
    unique case (st)
      IDLE:  if (enable && amp != 4'd0) st_nx = RUN;
      RUN:   if (!enable || amp == 4'd0) st_nx = STOP;
      STOP:  if (boundary) st_nx = IDLE;
      FAULT: if (clear && !enable) st_nx = IDLE;
    endcase
    if (trip) st_nx = FAULT;
    leave_idle = (st == IDLE) && (st_nx == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      freq      <= 4'(FREQ_INIT);
      amp       <= 4'(AMP_INIT);
      freq_act  <= 4'(FREQ_INIT);
      pre       <= '0;
      hp_cnt    <= '0;
      pwm_cnt   <= '0;
      err_cnt   <= '0;
      motor_pwm <= 1'b0;
      motor_dir <= 1'b0;
`ifdef ROCK_DRIVER_SOFTSTART_EN
      ss_lvl    <= '0;
`endif
    end else begin
      st        <= st_nx;
      freq      <= freq_nx;
      amp       <= amp_nx;
      err_cnt   <= (st == FAULT && st_nx == IDLE) ? '0 : err_nx;
      motor_pwm <= (st_nx == RUN) && (pwm_cnt < amp_eff);
      pwm_cnt   <= (st == RUN && st_nx == RUN) ? pwm_cnt + 4'd1 : '0;
      if (boundary || leave_idle) freq_act <= freq;
      if (running && (st_nx == RUN || st_nx == STOP)) begin
        if (pre == PRE_MAX) begin
          pre    <= '0;
          hp_cnt <= boundary ? '0 : hp_cnt + 4'd1;
        end else begin
          pre    <= pre + 1'b1;
        end
      end else begin
        pre    <= '0;
        hp_cnt <= '0;
      end
      if (st_nx == IDLE || st_nx == FAULT) motor_dir <= 1'b0;
      else if (boundary)                   motor_dir <= ~motor_dir;
`ifdef ROCK_DRIVER_SOFTSTART_EN
      if (leave_idle)                       ss_lvl <= 4'd1;
      else if (boundary && amp_eff < amp)   ss_lvl <= amp_eff + 4'd1;
      else                                  ss_lvl <= amp_eff;
`endif
    end
  end

  assign state = st;
  assign fault = (st == FAULT);

endmodule
